// File: rtl/riscv_defines.sv
// Shared DIFT definitions: TCR check-bit positions, store-tag FSM states and cause bit indices.
package riscv_defines;

  localparam int LOADSTORE_CHECK_S  = 0;
  localparam int LOADSTORE_CHECK_SA = 1;
  localparam int LOADSTORE_CHECK_D  = 2;

  localparam int STCAUSE_S  = 0;
  localparam int STCAUSE_SA = 1;
  localparam int STCAUSE_D  = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    REPORT
  } store_tag_state_e;

  // Every byte written by a store inherits the single source-data tag.
  function automatic logic [3:0] spread_tag(input logic tag);
    return {4{tag}};
  endfunction

endpackage

// File: rtl/riscv_store_check.sv
// Combinational DIFT store checks: source/address tag policy and destination byte-tag policy.
module riscv_store_check (
  input  logic       rs2_tag,
  input  logic       rs1_tag,
  input  logic       check_s,
  input  logic       check_sa,
  input  logic [3:0] be,
  input  logic [3:0] dst_tags,
  output logic       s_fail,
  output logic       sa_fail,
  output logic       src_fail,
  output logic       dst_fail
);

  assign s_fail   = rs2_tag & check_s;
  assign sa_fail  = rs1_tag & check_sa;
  assign src_fail = s_fail | sa_fail;

  // Only bytes actually overwritten by this store may trip the destination check.
  assign dst_fail = |(dst_tags & be);

endmodule

// File: rtl/riscv_store_tag_unit.sv
// DIFT store tag unit: checks source/address/destination tags and writes byte tags to tag memory.
// Optional macro DIFT_STORE_CAUSE_EN adds sticky exception_cause_o and cause_clr_i.
module riscv_store_tag_unit
  import riscv_defines::*;
#(
  parameter int TAG_AW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              store_req_i,
  output logic              store_gnt_o,
  input  logic [TAG_AW-1:0] addr_i,
  input  logic [3:0]        be_i,
  input  logic              rs2_tag_i,
  input  logic              rs1_tag_i,
  input  logic [31:0]       tcr_i,
  output logic              tag_req_o,
  output logic              tag_we_o,
  output logic [TAG_AW-1:0] tag_addr_o,
  output logic [3:0]        tag_be_o,
  output logic [3:0]        tag_wdata_o,
  input  logic              tag_gnt_i,
  input  logic              tag_rvalid_i,
  input  logic [3:0]        tag_rdata_i,
  output logic              exception_o,
  output logic              done_o,
  output logic              busy_o
`ifdef DIFT_STORE_CAUSE_EN
  ,
  output logic [2:0]        exception_cause_o,
  input  logic              cause_clr_i
`endif
);

  store_tag_state_e state;
  logic [3:0]       be_q;
  logic             rs2_tag_q;
  logic             s_fail;
  logic             sa_fail;
  logic             src_fail;
  logic             dst_fail;
  logic             unused_bits;

  assign store_gnt_o = (state == IDLE);
  assign unused_bits = ^{tcr_i, addr_i[1:0]};

  riscv_store_check u_check (
    .rs2_tag  (rs2_tag_i),
    .rs1_tag  (rs1_tag_i),
    .check_s  (tcr_i[LOADSTORE_CHECK_S]),
    .check_sa (tcr_i[LOADSTORE_CHECK_SA]),
    .be       (be_q),
    .dst_tags (tag_rdata_i),
    .s_fail   (s_fail),
    .sa_fail  (sa_fail),
    .src_fail (src_fail),
    .dst_fail (dst_fail)
  );

  // All completions pass through REPORT so a new store can never be granted alongside done/exception.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      be_q        <= 4'b0;
      rs2_tag_q   <= 1'b0;
      tag_req_o   <= 1'b0;
      tag_we_o    <= 1'b0;
      tag_addr_o  <= '0;
      tag_be_o    <= 4'b0;
      tag_wdata_o <= 4'b0;
      exception_o <= 1'b0;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      exception_o <= 1'b0;
      done_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (store_req_i) begin
            tag_addr_o <= {addr_i[TAG_AW-1:2], 2'b00};
            tag_be_o   <= be_i;
            be_q       <= be_i;
            rs2_tag_q  <= rs2_tag_i;
            busy_o     <= 1'b1;
            if (src_fail) begin
              state       <= REPORT;
              exception_o <= 1'b1;
            end else if (be_i == 4'b0) begin
              state  <= REPORT;
              done_o <= 1'b1;
            end else if (tcr_i[LOADSTORE_CHECK_D]) begin
              state       <= RD_REQ;
              tag_req_o   <= 1'b1;
              tag_we_o    <= 1'b0;
              tag_wdata_o <= 4'b0;
            end else begin
              state       <= WR_REQ;
              tag_req_o   <= 1'b1;
              tag_we_o    <= 1'b1;
              tag_wdata_o <= spread_tag(rs2_tag_i);
            end
          end
        end
        RD_REQ: begin
          if (tag_gnt_i) begin
            state     <= RD_WAIT;
            tag_req_o <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (tag_rvalid_i) begin
            if (dst_fail) begin
              state       <= REPORT;
              exception_o <= 1'b1;
            end else begin
              state       <= WR_REQ;
              tag_req_o   <= 1'b1;
              tag_we_o    <= 1'b1;
              tag_wdata_o <= spread_tag(rs2_tag_q);
            end
          end
        end
        WR_REQ: begin
          if (tag_gnt_i) begin
            state     <= WR_WAIT;
            tag_req_o <= 1'b0;
            tag_we_o  <= 1'b0;
          end
        end
        WR_WAIT: begin
          if (tag_rvalid_i) begin
            state  <= REPORT;
            done_o <= 1'b1;
          end
        end
        REPORT: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          tag_req_o <= 1'b0;
          tag_we_o  <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIFT_STORE_CAUSE_EN
  logic [2:0] cause_set;

  always_comb begin
    cause_set = 3'b0;
    if (state == IDLE && store_req_i && src_fail) begin
      cause_set[STCAUSE_S]  = s_fail;
      cause_set[STCAUSE_SA] = sa_fail;
    end
    if (state == RD_WAIT && tag_rvalid_i && dst_fail) begin
      cause_set[STCAUSE_D] = 1'b1;
    end
  end

  // Causes accumulate across exceptions; a new cause lands even in the cycle it is being cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exception_cause_o <= 3'b0;
    end else if (cause_clr_i) begin
      exception_cause_o <= cause_set;
    end else begin
      exception_cause_o <= exception_cause_o | cause_set;
    end
  end
`else
  logic unused_cause;
  assign unused_cause = s_fail ^ sa_fail;
`endif

endmodule

// File: tb/tb_riscv_store_tag_unit.sv
// Scoreboard bench for riscv_store_tag_unit: directed stores, tag-memory responder model, response monitor.
module tb_riscv_store_tag_unit;
  import riscv_defines::*;

  localparam int TAG_AW = 32;

  logic              clk;
  logic              rst_n;
  logic              store_req_i;
  logic              store_gnt_o;
  logic [TAG_AW-1:0] addr_i;
  logic [3:0]        be_i;
  logic              rs2_tag_i;
  logic              rs1_tag_i;
  logic [31:0]       tcr_i;
  logic              tag_req_o;
  logic              tag_we_o;
  logic [TAG_AW-1:0] tag_addr_o;
  logic [3:0]        tag_be_o;
  logic [3:0]        tag_wdata_o;
  logic              tag_gnt_i;
  logic              tag_rvalid_i;
  logic [3:0]        tag_rdata_i;
  logic              exception_o;
  logic              done_o;
  logic              busy_o;
`ifdef DIFT_STORE_CAUSE_EN
  logic [2:0]        exception_cause_o;
  logic              cause_clr_i;
`endif

  typedef struct {
    logic is_exc;
    int   lat;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [3:0]  wdata;
  } mem_t;

  resp_t       exp_q[$];
  mem_t        mem_q[$];
  int          checks;
  int          errors;
  int          cyc;
  int          accept_cyc;
  int          gnt_wait;
  int          rv_delay;
  int          wait_ctr;
  int          rv_cnt;
  logic [3:0]  mem_rdata;

  riscv_store_tag_unit #(.TAG_AW(TAG_AW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .store_req_i       (store_req_i),
    .store_gnt_o       (store_gnt_o),
    .addr_i            (addr_i),
    .be_i              (be_i),
    .rs2_tag_i         (rs2_tag_i),
    .rs1_tag_i         (rs1_tag_i),
    .tcr_i             (tcr_i),
    .tag_req_o         (tag_req_o),
    .tag_we_o          (tag_we_o),
    .tag_addr_o        (tag_addr_o),
    .tag_be_o          (tag_be_o),
    .tag_wdata_o       (tag_wdata_o),
    .tag_gnt_i         (tag_gnt_i),
    .tag_rvalid_i      (tag_rvalid_i),
    .tag_rdata_i       (tag_rdata_i),
    .exception_o       (exception_o),
    .done_o            (done_o),
    .busy_o            (busy_o)
`ifdef DIFT_STORE_CAUSE_EN
    ,
    .exception_cause_o (exception_cause_o),
    .cause_clr_i       (cause_clr_i)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expectMem(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [3:0] wdata);
    mem_t m;
    m.we = we; m.addr = addr; m.be = be; m.wdata = wdata;
    mem_q.push_back(m);
  endtask

  // lat < 0: the store is expected to be cut short and produce no response.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] be, input logic rs2,
                               input logic rs1, input logic [31:0] tcr, input logic is_exc,
                               input int lat);
    resp_t r;
    int    n;
    if (lat >= 0) begin
      r.is_exc = is_exc;
      r.lat    = lat;
      exp_q.push_back(r);
    end
    store_req_i = 1'b1;
    addr_i      = addr;
    be_i        = be;
    rs2_tag_i   = rs2;
    rs1_tag_i   = rs1;
    tcr_i       = tcr;
    n = 0;
    while (!store_gnt_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!store_gnt_o) checkOutput("accept_timeout", 32'd0, 32'd1);
    accept_cyc = cyc;
    @(negedge clk);
    store_req_i = 1'b0;
    addr_i      = ~addr;
    be_i        = ~be;
    rs2_tag_i   = ~rs2;
    rs1_tag_i   = ~rs1;
    tcr_i       = ~tcr;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0 || busy_o) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) checkOutput("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  // Tag memory model: grants after gnt_wait cycles, returns rvalid rv_delay cycles after the grant.
  initial begin
    tag_gnt_i    = 1'b0;
    tag_rvalid_i = 1'b0;
    tag_rdata_i  = 4'b0;
    wait_ctr     = 0;
    rv_cnt       = 0;
    forever begin
      @(negedge clk);
      tag_gnt_i    = 1'b0;
      tag_rvalid_i = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          tag_rvalid_i = 1'b1;
          tag_rdata_i  = mem_rdata;
        end
      end
      if (rst_n && tag_req_o) begin
        if (mem_q.size() == 0) begin
          checkOutput("unexpected_tag_req", {31'd0, tag_req_o}, 32'd0);
          tag_gnt_i = 1'b1;
          rv_cnt    = rv_delay;
        end else begin
          checkOutput("tag_we", {31'd0, tag_we_o}, {31'd0, mem_q[0].we});
          checkOutput("tag_addr", tag_addr_o, mem_q[0].addr);
          checkOutput("tag_be", {28'd0, tag_be_o}, {28'd0, mem_q[0].be});
          if (mem_q[0].we) checkOutput("tag_wdata", {28'd0, tag_wdata_o}, {28'd0, mem_q[0].wdata});
          if (wait_ctr < gnt_wait) begin
            wait_ctr++;
          end else begin
            tag_gnt_i = 1'b1;
            wait_ctr  = 0;
            rv_cnt    = rv_delay;
            void'(mem_q.pop_front());
          end
        end
      end
    end
  end

  // Response monitor: every done/exception pulse is matched against the scoreboard.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst_n && (done_o || exception_o)) begin
        checkOutput("done_exc_exclusive", {31'd0, done_o & exception_o}, 32'd0);
        checkOutput("no_gnt_with_resp", {31'd0, store_gnt_o}, 32'd0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_resp", {30'd0, exception_o, done_o}, 32'd0);
        end else begin
          r = exp_q.pop_front();
          checkOutput("resp_is_exc", {31'd0, exception_o}, {31'd0, r.is_exc});
          checkOutput("resp_latency", cyc - accept_cyc, r.lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    accept_cyc  = 0;
    gnt_wait    = 0;
    rv_delay    = 1;
    mem_rdata   = 4'b0;
    rst_n       = 1'b0;
    store_req_i = 1'b0;
    addr_i      = '0;
    be_i        = 4'b0;
    rs2_tag_i   = 1'b0;
    rs1_tag_i   = 1'b0;
    tcr_i       = 32'd0;
`ifdef DIFT_STORE_CAUSE_EN
    cause_clr_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_tag_req", {31'd0, tag_req_o}, 32'd0);
    checkOutput("rst_tag_we", {31'd0, tag_we_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_exc_done", {30'd0, exception_o, done_o}, 32'd0);
    checkOutput("rst_tag_addr", tag_addr_o, 32'd0);
    checkOutput("rst_be_wdata", {24'd0, tag_be_o, tag_wdata_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_gnt", {31'd0, store_gnt_o}, 32'd1);

    // Source-data tag check fires: exception one cycle later, no memory access
    applyStimulus(32'h2000, 4'hF, 1'b1, 1'b0, 32'd1 << LOADSTORE_CHECK_S, 1'b1, 1);
    waitIdle();

    // Unchecked write, misaligned address
    expectMem(1'b1, 32'h1004, 4'b1100, 4'hF);
    applyStimulus(32'h1006, 4'b1100, 1'b1, 1'b0, 32'd0, 1'b0, 3);
    waitIdle();

    // Destination check passes: read then write
    mem_rdata = 4'b0001;
    expectMem(1'b0, 32'h3000, 4'b0010, 4'h0);
    expectMem(1'b1, 32'h3000, 4'b0010, 4'hF);
    applyStimulus(32'h3001, 4'b0010, 1'b1, 1'b0, 32'd1 << LOADSTORE_CHECK_D, 1'b0, 5);
    waitIdle();

    // Destination check fires: read only, exception
    mem_rdata = 4'b0010;
    expectMem(1'b0, 32'h3000, 4'b0010, 4'h0);
    applyStimulus(32'h3001, 4'b0010, 1'b1, 1'b0, 32'd1 << LOADSTORE_CHECK_D, 1'b1, 3);
    waitIdle();

    // Address tag check fires
    applyStimulus(32'h4000, 4'hF, 1'b0, 1'b1, 32'd1 << LOADSTORE_CHECK_SA, 1'b1, 1);
    waitIdle();

    // Zero byte enables: immediate done, no memory access
    applyStimulus(32'h5000, 4'h0, 1'b1, 1'b1, 32'd0, 1'b0, 1);
    waitIdle();

    // S check enabled but clean data tag, tainted base with SA disabled
    expectMem(1'b1, 32'h6008, 4'b0011, 4'h0);
    applyStimulus(32'h600B, 4'b0011, 1'b0, 1'b1, 32'd1 << LOADSTORE_CHECK_S, 1'b0, 3);
    waitIdle();

    // Grant withheld 4 cycles during WR_REQ
    gnt_wait = 4;
    expectMem(1'b1, 32'h7004, 4'b0001, 4'hF);
    applyStimulus(32'h7004, 4'b0001, 1'b1, 1'b0, 32'd0, 1'b0, 7);
    waitIdle();
    gnt_wait = 0;

    // Reset in RD_WAIT with a late rvalid afterwards
    rv_delay  = 4;
    mem_rdata = 4'b0;
    expectMem(1'b0, 32'h8000, 4'hF, 4'h0);
    applyStimulus(32'h8000, 4'hF, 1'b0, 1'b0, 32'd1 << LOADSTORE_CHECK_D, 1'b0, -1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("mid_rst_tag_req", {31'd0, tag_req_o}, 32'd0);
    checkOutput("mid_rst_gnt", {31'd0, store_gnt_o}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("late_rvalid_ignored", {31'd0, busy_o}, 32'd0);
    rv_delay = 1;

    // Normal read+write store after reset
    expectMem(1'b0, 32'h9000, 4'hF, 4'h0);
    expectMem(1'b1, 32'h9000, 4'hF, 4'h0);
    applyStimulus(32'h9002, 4'hF, 1'b0, 1'b0, 32'd1 << LOADSTORE_CHECK_D, 1'b0, 5);
    waitIdle();

`ifdef DIFT_STORE_CAUSE_EN
    cause_clr_i = 1'b1;
    @(negedge clk);
    cause_clr_i = 1'b0;
    checkOutput("cause_initial_clear", {29'd0, exception_cause_o}, 32'd0);
    applyStimulus(32'hA000, 4'hF, 1'b0, 1'b1, 32'd1 << LOADSTORE_CHECK_SA, 1'b1, 1);
    waitIdle();
    mem_rdata = 4'b0100;
    expectMem(1'b0, 32'hA000, 4'b0100, 4'h0);
    applyStimulus(32'hA002, 4'b0100, 1'b0, 1'b0, 32'd1 << LOADSTORE_CHECK_D, 1'b1, 3);
    waitIdle();
    checkOutput("cause_sticky", {29'd0, exception_cause_o}, 32'd6);
    cause_clr_i = 1'b1;
    @(negedge clk);
    cause_clr_i = 1'b0;
    checkOutput("cause_cleared", {29'd0, exception_cause_o}, 32'd0);
`endif

    checkOutput("resp_queue_drained", exp_q.size(), 32'd0);
    checkOutput("mem_queue_drained", mem_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
